// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V sequencer.
// Holds opcode constants, ALUOp / ALUControl / ImmSrc / ResultSrc / ALU source
// encodings, the FSM state type with its state constants, and the ImmSrc
// decode helper used by the controller.
package mc_ctrl_pkg;

  // Opcodes recognised by the sequencer
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALUOp from the sequencer to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate formats
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Writeback / PC result mux
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALU operand muxes
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // FSM state encoding
  typedef logic [3:0] state_t;
  localparam state_t ST_FETCH    = 4'd0;
  localparam state_t ST_DECODE   = 4'd1;
  localparam state_t ST_MEMADR   = 4'd2;
  localparam state_t ST_MEMREAD  = 4'd3;
  localparam state_t ST_MEMWB    = 4'd4;
  localparam state_t ST_MEMWRITE = 4'd5;
  localparam state_t ST_EXECR    = 4'd6;
  localparam state_t ST_EXECI    = 4'd7;
  localparam state_t ST_ALUWB    = 4'd8;
  localparam state_t ST_JAL      = 4'd9;
  localparam state_t ST_BEQ      = 4'd10;
  localparam state_t ST_TRAP     = 4'd11;

  // Immediate format selected purely by opcode; formats without an
  // immediate (R-type, unknown) fall back to I.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Memory-port handshake between the sequencer and the single memory port.
//   mem_req   : access active, AdrSrc/MemWrite valid (controller -> memory)
//   AdrSrc    : 0 = PC, 1 = ALUOut as address      (controller -> memory)
//   MemWrite  : store strobe                        (controller -> memory)
//   mem_ready : memory completes access this cycle  (memory -> controller)
interface mc_ctrl_if;
  logic mem_req;
  logic AdrSrc;
  logic MemWrite;
  logic mem_ready;

  modport master (
    output mem_req,
    output AdrSrc,
    output MemWrite,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  AdrSrc,
    input  MemWrite,
    output mem_ready
  );
endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// Combinational ALU decoder.
//   alu_op_i   : 00 add, 01 sub, 10 decode from funct fields
//   funct3_i   : IR[14:12]
//   funct7_i   : IR[30]
//   op5_i      : opcode bit 5 (distinguishes R-type from I-type ALU ops)
//   alu_ctrl_o : ALUControl
module mc_ctrl_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_i,
  input  logic       op5_i,
  output logic [2:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // IR[30] only means sub for R-type; addi keeps immediate bits there
          3'b000:  alu_ctrl_o = (op5_i & funct7_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b111:  alu_ctrl_o = ALU_AND;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer: walks each instruction through fetch / decode /
// execute / memory / writeback, driving the shared ALU, the single memory
// port and the register file. Stalls on mem_ready, traps on unknown opcodes.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   mem          : memory handshake (mem_req, AdrSrc, MemWrite / mem_ready)
//   op, funct3, funct7 : instruction fields from the IR
//   Zero         : ALU zero flag
//   IRWrite, PCWrite, RegWrite : strobes
//   ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl : datapath selects
//   instr_done   : pulse in the last cycle of each instruction
//   illegal      : high while trapped
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mc_ctrl_if.master        mem,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7,
  input  logic             Zero,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             instr_done,
  output logic             illegal
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       mem_req_c, adr_src_c, mem_write_c;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    adr_src_c   = 1'b0;
    mem_write_c = 1'b0;
    IRWrite     = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    ResultSrc   = RES_ALUOUT;
    alu_op      = ALUOP_ADD;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // PC+4 goes straight from the ALU into PC while IR captures the word
        mem_req_c = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = mem.mem_ready;
        pc_update = mem.mem_ready;
        if (mem.mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // OldPC + imm lands in ALUOut as the branch target for BEQ
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_R:         state_d = ST_EXECR;
          OP_I:         state_d = ST_EXECI;
          OP_JAL:       state_d = ST_JAL;
          OP_BEQ:       state_d = ST_BEQ;
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem.mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        ResultSrc  = RES_MEM;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEMWRITE: begin
        mem_req_c   = 1'b1;
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        if (mem.mem_ready) begin
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
        state_d = ST_ALUWB;
      end
      ST_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = ST_ALUWB;
      end
      ST_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_JAL: begin
        // PC <- jump target from ALUOut, ALU forms OldPC+4 for the link write
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        pc_update = 1'b1;
        state_d   = ST_ALUWB;
      end
      ST_BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        ResultSrc  = RES_ALUOUT;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign PCWrite      = pc_update | (branch & Zero);
  assign ImmSrc       = imm_src(op);
  assign mem.mem_req  = mem_req_c;
  assign mem.AdrSrc   = adr_src_c;
  assign mem.MemWrite = mem_write_c;

  mc_ctrl_alu_dec u_alu_dec (
    .alu_op_i   (alu_op),
    .funct3_i   (funct3),
    .funct7_i   (funct7),
    .op5_i      (op[5]),
    .alu_ctrl_o (ALUControl)
  );

endmodule
